fir_axis_param: RTL and testbench
=================================

Name: fir_axis_param

Overview:
- Parametrised AXI-Stream FIR filter; successor to the fixed 16-in/32-out FIR.
- Generalises taps, data, coefficient and output widths.
- Adds runtime coefficient reload over a config stream, full backpressure, output shift/saturate, and optional per-packet delay-line flush on tlast.
- Sits between the sample source (DMA/ADC stream) and the downstream sink, on the same clock.

Parameters:
- DATA_W, 16: input sample width, signed.
- COEF_W, 16: coefficient width, signed.
- NTAPS, 8: number of taps; minimum 1, maximum 64.
- OUT_W, 32: output sample width, signed.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- FLUSH_ON_LAST, 0: if 1, the delay line is zeroed after an input beat with tlast is accepted.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_fir_tdata  in  DATA_W  input sample.
- s_axis_fir_tkeep  in  4  byte keep; passed through aligned with its sample.
- s_axis_fir_tlast  in  1  packet end.
- s_axis_fir_tvalid  in  1  input valid.
- s_axis_fir_tready  out  1  input ready.
- m_axis_fir_tdata  out  OUT_W  filtered sample.
- m_axis_fir_tkeep  out  4  delayed keep.
- m_axis_fir_tlast  out  1  delayed last.
- m_axis_fir_tvalid  out  1  output valid.
- m_axis_fir_tready  in  1  output ready.
- cfg_tdata  in  COEF_W  coefficient word.
- cfg_tvalid  in  1  coefficient valid.
- cfg_tlast  in  1  last coefficient of the set.
- cfg_tready  out  1  coefficient ready.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. All outputs are registered.
- Reset values:
  - All m_* outputs 0; s_axis_fir_tready 0; cfg_tready 0.
  - Delay line and pipeline cleared.
  - Coefficients = identity: coef[0]=1, others 0.
  - State RUN.
- Readiness:
  - s_axis_fir_tready and cfg_tready are 0 on the cycle following any cycle in which reset is high.
  - A reset asserted mid-packet or mid-load discards everything in flight.
- Pipeline advance: adv = !m_axis_fir_tvalid || m_axis_fir_tready. All stages hold when adv=0.
- Input acceptance: s_axis_fir_tready = adv && state==RUN. A sample is accepted on tvalid && tready.
- On accept:
  - Delay line shifts: x[0] <= tdata, x[k] <= x[k-1].
  - Stage 1 registers the NTAPS products coef[k]*x[k], using the new x[0].
  - tkeep, tlast and a valid bit travel alongside the data.
- Stage 2:
  - Sums the products in an ACC_W = DATA_W+COEF_W+clog2(NTAPS) accumulator.
  - Applies an arithmetic shift right by SHIFT.
  - Saturates to OUT_W: max 2^(OUT_W-1)-1, min -2^(OUT_W-1). No wrap permitted.
  - Result goes to the output registers.
- Latency and throughput:
  - Exactly 2 cycles from input handshake to m_axis_fir_tvalid when unstalled.
  - One sample per cycle sustained.
  - Output data is held stable while tvalid=1 and tready=0.
- FLUSH_ON_LAST=1: on accepting a beat with tlast=1, the delay line is zeroed in the following advance. The next sample's output uses zero history. The tlast beat's own output is unaffected.
- FSM, RUN -> DRAIN -> LOAD -> RUN:
  - RUN: cfg_tvalid=1 moves to DRAIN; input acceptance stops the same cycle.
  - DRAIN: wait until both pipeline stages are empty and m_axis_fir_tvalid=0, then go to LOAD.
  - LOAD: cfg_tready=1. Each cfg handshake writes coef[idx], then idx++.
    - Exit to RUN when cfg_tlast is accepted or idx reaches NTAPS-1.
    - Unwritten taps are set to 0.
    - Extra words after NTAPS are not consumed (cfg_tready=0 in RUN).
    - The delay line is zeroed on entry to RUN.
  - Simultaneous s_axis_fir_tvalid and cfg_tvalid in RUN: configuration wins; the sample is not accepted.
- Zero-tap corner: NTAPS=1 degenerates to a scaled, saturated passthrough.

Decomposition:
- Package fir_axis_pkg holds:
  - the state enum (RUN, DRAIN, LOAD);
  - the function clog2;
  - the function acc_width(DATA_W, COEF_W, NTAPS);
  - the function sat_shift(acc, SHIFT, OUT_W).
- One natural sub-module: fir_adder_tree, a parametrised registered sum of NTAPS signed products used by stage 2.
- The top level holds the FSM, delay line, coefficient registers and handshake.

Test Plan:
- Reset, then stream 1,2,3,4 with identity coefficients (SHIFT=0) and m_tready=1 -> outputs 1,2,3,4; each appears 2 cycles after its input handshake; tkeep and tlast aligned.
- Load coefficients 1,1,1,1 with cfg_tlast on the 4th word (NTAPS=8), then send an impulse 100 followed by seven 0s -> outputs 100,100,100,100,0,0,0,0.
- DATA_W=16 and COEF_W=16 with coefficients all 32767, input 32767 repeated, OUT_W=16 -> output saturates at 32767; with input -32768 -> saturates at -32768. No wrap.
- Hold m_tready=0 for 5 cycles mid-stream -> s_axis_fir_tready drops; m_tdata stays stable; no sample is lost or duplicated; the sequence after release is identical to the unstalled reference model.
- FLUSH_ON_LAST=1 with coefficients 1,1 on a 2-tap filter: send packet 5,7(last), then 3 -> outputs 5,12,3 (not 10).
- Assert cfg_tvalid while samples are in flight -> pipeline drains, in-flight outputs are delivered, and no input is accepted until the load completes. Assert reset mid-load -> coefficients return to identity and all outputs are 0 the next cycle.

Source files
------------

// File: rtl/fir_axis_pkg.sv
// Shared types and width/saturation helpers for the parametrised AXI-Stream FIR.
// Everything here is elaboration-time or pure combinational arithmetic.
package fir_axis_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} fir_state_e;

  // Wide enough for any legal accumulator (64 taps of 32x32 products still fit).
  localparam int WIDE_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int nt);
    return dw + cw + clog2(nt);
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_shift(
    input logic signed [WIDE_W-1:0] acc,
    input int                       shift,
    input int                       out_w
  );
    logic signed [WIDE_W-1:0] s;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    s = acc >>> shift;
    hi = '0;
    hi[out_w-1] = 1'b1;
    hi = hi - WIDE_W'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fir_axis_param_adder_tree.sv
// Stage 2 of the FIR: sums the registered tap products, shifts, saturates and
// registers the result as the output sample.
module fir_adder_tree
  import fir_axis_pkg::*;
#(
  parameter int NTAPS  = 8,
  parameter int PROD_W = 32,
  parameter int ACC_W  = 35,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_en,
  input  logic [NTAPS-1:0][PROD_W-1:0]  i_prod,
  output logic signed [OUT_W-1:0]       o_sum
);

  logic signed [ACC_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      w_sum = w_sum + ACC_W'($signed(i_prod[k]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_sum <= '0;
    end else if (i_en) begin
      o_sum <= OUT_W'(sat_shift(WIDE_W'(w_sum), SHIFT, OUT_W));
    end
  end

endmodule

// File: rtl/fir_axis_param.sv
// Parametrised two-stage AXI-Stream FIR with runtime coefficient reload,
// full backpressure, shift/saturate output and optional flush on tlast.
module fir_axis_param
  import fir_axis_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int COEF_W        = 16,
  parameter int NTAPS         = 8,
  parameter int OUT_W         = 32,
  parameter int SHIFT         = 0,
  parameter int FLUSH_ON_LAST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_fir_tdata,
  input  logic [3:0]        s_axis_fir_tkeep,
  input  logic              s_axis_fir_tlast,
  input  logic              s_axis_fir_tvalid,
  output logic              s_axis_fir_tready,
  output logic [OUT_W-1:0]  m_axis_fir_tdata,
  output logic [3:0]        m_axis_fir_tkeep,
  output logic              m_axis_fir_tlast,
  output logic              m_axis_fir_tvalid,
  input  logic              m_axis_fir_tready,
  input  logic [COEF_W-1:0] cfg_tdata,
  input  logic              cfg_tvalid,
  input  logic              cfg_tlast,
  output logic              cfg_tready
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int IDX_W  = (NTAPS > 1) ? clog2(NTAPS) : 1;
  localparam int HIST   = (NTAPS > 1) ? NTAPS - 1 : 1;

  fir_state_e r_state;
  fir_state_e w_next;

  logic signed [COEF_W-1:0]    r_coef [NTAPS];
  logic signed [DATA_W-1:0]    r_hist [HIST];
  logic signed [DATA_W-1:0]    w_xnew [NTAPS];
  logic [NTAPS-1:0][PROD_W-1:0] w_prod;
  logic [NTAPS-1:0][PROD_W-1:0] r_s1_prod;
  logic                        r_s1_valid;
  logic                        r_s1_last;
  logic [3:0]                  r_s1_keep;
  logic                        r_m_valid;
  logic                        r_m_last;
  logic [3:0]                  r_m_keep;
  logic signed [OUT_W-1:0]     w_tree_out;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_rdy_en;
  logic                        w_adv;
  logic                        w_accept;
  logic                        w_cfg_hs;
  logic                        w_load_done;

  // r_rdy_en keeps the input closed for the first cycle after any reset cycle.
  assign w_adv             = !r_m_valid || m_axis_fir_tready;
  assign s_axis_fir_tready = r_rdy_en && w_adv && (r_state == RUN) && !cfg_tvalid;
  assign w_accept          = s_axis_fir_tvalid && s_axis_fir_tready;
  assign cfg_tready        = (r_state == LOAD);
  assign w_cfg_hs          = cfg_tvalid && cfg_tready;
  assign w_load_done       = w_cfg_hs && (cfg_tlast || (r_idx == IDX_W'(NTAPS - 1)));

  assign m_axis_fir_tdata  = w_tree_out;
  assign m_axis_fir_tkeep  = r_m_keep;
  assign m_axis_fir_tlast  = r_m_last;
  assign m_axis_fir_tvalid = r_m_valid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (cfg_tvalid) w_next = DRAIN;
      DRAIN:   if (!r_s1_valid && !r_m_valid) w_next = LOAD;
      LOAD:    if (w_load_done) w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // Products use the delay line as it will look after this sample shifts in.
  always_comb begin
    w_xnew[0] = s_axis_fir_tdata;
    for (int k = 1; k < NTAPS; k++) begin
      w_xnew[k] = r_hist[k-1];
    end
    for (int k = 0; k < NTAPS; k++) begin
      w_prod[k] = PROD_W'(r_coef[k]) * PROD_W'(w_xnew[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy_en   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_keep  <= '0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
      r_m_valid  <= 1'b0;
      r_m_keep   <= '0;
      r_m_last   <= 1'b0;
      r_idx      <= '0;
      for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
      r_coef[0] <= COEF_W'(1);
      for (int k = 0; k < HIST; k++) r_hist[k] <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_prod <= w_prod;
          r_s1_keep <= s_axis_fir_tkeep;
          r_s1_last <= s_axis_fir_tlast;
        end
        r_m_valid <= r_s1_valid;
        r_m_keep  <= r_s1_keep;
        r_m_last  <= r_s1_last;
      end
      if (w_accept) begin
        for (int k = 0; k < HIST; k++) begin
          r_hist[k] <= ((FLUSH_ON_LAST != 0) && s_axis_fir_tlast) ? '0 : w_xnew[k];
        end
      end
      // A new coefficient set starts from all-zero taps.
      if ((r_state == DRAIN) && (w_next == LOAD)) begin
        for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
        r_idx <= '0;
      end
      if (w_cfg_hs) begin
        r_coef[r_idx] <= cfg_tdata;
        r_idx         <= r_idx + 1'b1;
      end
      if (w_load_done) begin
        for (int k = 0; k < HIST; k++) r_hist[k] <= '0;
      end
    end
  end

  fir_adder_tree #(
    .NTAPS  (NTAPS),
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .OUT_W  (OUT_W)
  ) u_tree (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_adv),
    .i_prod (r_s1_prod),
    .o_sum  (w_tree_out)
  );

endmodule

// File: tb/tb_fir_axis_param.sv
// Scoreboard bench for fir_axis_param: 8 taps, 16-bit output, flush on tlast.
// Expected samples are queued at input handshake and checked as outputs leave.
module tb_fir_axis_param;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 8;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [DW-1:0]        sTdata = '0;
  logic [3:0]           sTkeep = '0;
  logic                 sTlast = 1'b0;
  logic                 sTvalid = 1'b0;
  logic                 sTready;
  logic signed [OW-1:0] mTdata;
  logic [3:0]           mTkeep;
  logic                 mTlast;
  logic                 mTvalid;
  logic                 mTready = 1'b1;
  logic [CW-1:0]        cfgTdata = '0;
  logic                 cfgTvalid = 1'b0;
  logic                 cfgTlast = 1'b0;
  logic                 cfgTready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chkLat = 1'b0;

  typedef struct {
    int         data;
    logic [3:0] keep;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   monE;
  longint mCoef[NT];
  longint mHist[NT];

  fir_axis_param #(
    .DATA_W(DW), .COEF_W(CW), .NTAPS(NT), .OUT_W(OW), .SHIFT(0), .FLUSH_ON_LAST(1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_fir_tdata  (sTdata),
    .s_axis_fir_tkeep  (sTkeep),
    .s_axis_fir_tlast  (sTlast),
    .s_axis_fir_tvalid (sTvalid),
    .s_axis_fir_tready (sTready),
    .m_axis_fir_tdata  (mTdata),
    .m_axis_fir_tkeep  (mTkeep),
    .m_axis_fir_tlast  (mTlast),
    .m_axis_fir_tvalid (mTvalid),
    .m_axis_fir_tready (mTready),
    .cfg_tdata         (cfgTdata),
    .cfg_tvalid        (cfgTvalid),
    .cfg_tlast         (cfgTlast),
    .cfg_tready        (cfgTready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    for (int k = 0; k < NT; k++) begin
      mCoef[k] = (k == 0) ? 1 : 0;
      mHist[k] = 0;
    end
  endfunction

  // Behavioural reference: shift, multiply-accumulate, flush after tlast, clamp to 16 bits.
  function automatic longint modelStep(input int x, input logic l);
    longint acc;
    acc = 0;
    for (int k = NT - 1; k > 0; k--) mHist[k] = mHist[k-1];
    mHist[0] = x;
    for (int k = 0; k < NT; k++) acc += mCoef[k] * mHist[k];
    if (l) for (int k = 0; k < NT; k++) mHist[k] = 0;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  // Output monitor: scoreboard pop on handshake, plus hold check while stalled.
  logic signed [OW-1:0] prevData;
  bit prevStall = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checks++;
        if (mTdata !== prevData) begin
          failures++;
          $display("[TB] FAIL stall_hold got=%0d want=%0d", mTdata, prevData);
        end
      end
      prevStall = mTvalid && !mTready;
      prevData  = mTdata;
      if (mTvalid && mTready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_out got=%0d want=none", mTdata);
        end else begin
          monE = sb.pop_front();
          if (mTdata !== OW'(monE.data) || mTkeep !== monE.keep || mTlast !== monE.last) begin
            failures++;
            $display("[TB] FAIL out_beat got=%0d/%h/%0b want=%0d/%h/%0b",
                     mTdata, mTkeep, mTlast, monE.data, monE.keep, monE.last);
          end
          if (chkLat) begin
            checks++;
            if (cyc != monE.cyc + 2) begin
              failures++;
              $display("[TB] FAIL latency got=%0d want=%0d", cyc - monE.cyc, 2);
            end
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake with tvalid still high.
  task automatic sendSample(input int x, input logic [3:0] k, input logic l,
                            input int want, input bit useModel);
    int n;
    longint m;
    exp_t e;
    sTdata = DW'(x);
    sTkeep = k;
    sTlast = l;
    sTvalid = 1'b1;
    #1;
    n = 0;
    while (sTready !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sTready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL in_ready_timeout got=%0b want=1", sTready);
    end else begin
      m = modelStep(x, l);
      e.data = useModel ? int'(m) : want;
      e.keep = k;
      e.last = l;
      e.cyc  = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic loadCoefs(input int vals[NT], input int cnt, input bit useLast);
    int n;
    for (int k = 0; k < NT; k++) mCoef[k] = 0;
    for (int i = 0; i < cnt; i++) begin
      cfgTdata  = CW'(vals[i]);
      cfgTlast  = useLast && (i == cnt - 1);
      cfgTvalid = 1'b1;
      #1;
      n = 0;
      checks++;
      if (sTready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL in_ready_during_cfg got=%0b want=0", sTready);
      end
      while (cfgTready !== 1'b1 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
        checks++;
        if (sTready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL in_ready_during_drain got=%0b want=0", sTready);
        end
      end
      checks++;
      if (cfgTready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL cfg_ready_timeout got=%0b want=1", cfgTready);
      end
      mCoef[i] = vals[i];
      @(negedge clk);
    end
    cfgTvalid = 1'b0;
    cfgTlast  = 1'b0;
    for (int k = 0; k < NT; k++) mHist[k] = 0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mTvalid !== 1'b0 || mTdata !== '0 || mTkeep !== 4'h0 || mTlast !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_m_outputs got=%0b/%0d/%h/%0b want=0/0/0/0", mTvalid, mTdata, mTkeep, mTlast);
    end
    checks++;
    if (sTready !== 1'b0 || cfgTready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%0b/%0b want=0/0", sTready, cfgTready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (sTready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_after_reset got=%0b want=0", sTready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sTready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_reopen got=%0b want=1", sTready);
    end
    @(negedge clk);
  endtask

  task automatic test_identity();
    chkLat = 1'b1;
    sendSample(1, 4'hF, 1'b0, 1, 1'b0);
    sendSample(2, 4'h3, 1'b0, 2, 1'b0);
    sendSample(3, 4'h1, 1'b0, 3, 1'b0);
    sendSample(4, 4'hC, 1'b1, 4, 1'b0);
    sTvalid = 1'b0;
    waitDrain();
    chkLat = 1'b0;
  endtask

  task automatic test_impulse();
    int want[NT];
    want = '{100, 100, 100, 100, 0, 0, 0, 0};
    loadCoefs('{1, 1, 1, 1, 0, 0, 0, 0}, 4, 1'b1);
    for (int i = 0; i < NT; i++) begin
      sendSample((i == 0) ? 100 : 0, 4'hF, (i == NT - 1), want[i], 1'b0);
    end
    sTvalid = 1'b0;
    waitDrain();
  endtask

  task automatic test_saturation();
    loadCoefs('{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}, NT, 1'b0);
    for (int i = 0; i < NT; i++) sendSample(32767, 4'hF, (i == NT - 1), 32767, 1'b0);
    for (int i = 0; i < NT; i++) sendSample(-32768, 4'h5, (i == NT - 1), -32768, 1'b0);
    sTvalid = 1'b0;
    waitDrain();
  endtask

  task automatic test_flush();
    loadCoefs('{1, 1, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    sendSample(5, 4'hF, 1'b0, 5, 1'b0);
    sendSample(7, 4'hF, 1'b1, 12, 1'b0);
    sendSample(3, 4'hF, 1'b0, 3, 1'b0);
    sTvalid = 1'b0;
    waitDrain();
  endtask

  task automatic test_backpressure();
    loadCoefs('{3, -2, 1, 0, 0, 0, 0, 0}, 3, 1'b1);
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          sendSample(i * 37 - 150, 4'(i), (i == 11), 0, 1'b1);
        end
        sTvalid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        mTready = 1'b0;
        #1;
        checks++;
        if (sTready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stall_in_ready got=%0b want=0", sTready);
        end
        repeat (5) @(negedge clk);
        mTready = 1'b1;
      end
    join
    waitDrain();
  endtask

  task automatic test_back_to_back_reload();
    for (int i = 0; i < 5; i++) sendSample(i * 11 + 1, 4'hF, 1'b0, 0, 1'b1);
    sTdata = DW'(16'h7777);
    sTvalid = 1'b1;
    loadCoefs('{2, -1, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    sTvalid = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL inflight_delivered got=%0d want=0", sb.size());
    end
    sendSample(50, 4'h9, 1'b0, 0, 1'b1);
    sendSample(-20, 4'h6, 1'b1, 0, 1'b1);
    sTvalid = 1'b0;
    waitDrain();
  endtask

  task automatic test_reset_mid_load();
    int n;
    cfgTdata = CW'(7);
    cfgTlast = 1'b0;
    cfgTvalid = 1'b1;
    #1;
    n = 0;
    while (cfgTready !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (cfgTready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midload_ready got=%0b want=1", cfgTready);
    end
    @(negedge clk);
    cfgTdata = CW'(9);
    @(negedge clk);
    reset = 1'b1;
    cfgTvalid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mTvalid !== 1'b0 || mTdata !== '0 || mTkeep !== 4'h0 || mTlast !== 1'b0
        || sTready !== 1'b0 || cfgTready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midload_reset got=%0b/%0d/%h/%0b/%0b/%0b want=0/0/0/0/0/0",
               mTvalid, mTdata, mTkeep, mTlast, sTready, cfgTready);
    end
    reset = 1'b0;
    modelReset();
    sb.delete();
    @(negedge clk);
    sendSample(321, 4'hA, 1'b0, 321, 1'b0);
    sendSample(-45, 4'h2, 1'b1, -45, 1'b0);
    sTvalid = 1'b0;
    waitDrain();
  endtask

  initial begin
    modelReset();
    test_reset();
    test_identity();
    test_impulse();
    test_saturation();
    test_flush();
    test_backpressure();
    test_back_to_back_reload();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
